// File: rtl/audio_codec_config_sequencer.sv
// Codec configuration sequencer: streams an init table, then runtime host words,
// over a mode-0 SPI link and gates the I2S datapath once the codec is configured.
module audio_codec_config_sequencer #(
  parameter int INIT_WORDS = 8,
  parameter int SCLK_DIV   = 4,
  parameter int GAP_CYCLES = 8,
  localparam int ADDR_W    = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1
) (
  input  logic              serial_clk,
  input  logic              reset,
  input  logic              cfg_start,
  output logic [ADDR_W-1:0] init_addr,
  input  logic [15:0]       init_word,
  input  logic              host_req_valid,
  input  logic [15:0]       host_req_data,
  output logic              host_req_ready,
  output logic              spi_chip_select,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              init_done,
  output logic              stream_enable,
  output logic              busy
);

  localparam int DATA_W = 16;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(INIT_WORDS - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd15;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam logic MODE_INIT = 1'b0;
  localparam logic MODE_HOST = 1'b1;

  logic [2:0]        state;
  logic              mode;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              sclk_q;
  logic [DATA_W-1:0] shreg;
  logic              host_fire;
  logic              half_end;

  assign host_req_ready  = (state == S_RUN) && !cfg_start;
  assign host_fire       = host_req_valid && host_req_ready;
  assign half_end        = (state == S_SHIFT) && (div_cnt == DIV_LAST);
  assign spi_chip_select = (state != S_SHIFT);
  assign spi_sclk        = sclk_q;
  assign spi_mosi        = (state == S_SHIFT) && shreg[DATA_W-1];
  assign busy            = (state == S_LOAD) || (state == S_SHIFT) || (state == S_GAP);

  // Control path: state, handshake bookkeeping and SPI timing counters
  always_ff @(posedge serial_clk) begin
    if (reset) begin
      state         <= S_IDLE;
      mode          <= MODE_INIT;
      init_addr     <= '0;
      init_done     <= 1'b0;
      stream_enable <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      sclk_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (cfg_start) begin
            state         <= S_LOAD;
            mode          <= MODE_INIT;
            init_addr     <= '0;
            init_done     <= 1'b0;
            stream_enable <= 1'b0;
          end else if (host_fire) begin
            state   <= S_SHIFT;
            mode    <= MODE_HOST;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          state   <= S_SHIFT;
          div_cnt <= '0;
          bit_cnt <= '0;
          sclk_q  <= 1'b0;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (mode == MODE_HOST) begin
              state <= S_RUN;
            end else if (init_addr == ADDR_LAST) begin
              state         <= S_RUN;
              init_done     <= 1'b1;
              stream_enable <= 1'b1;
            end else begin
              state     <= S_LOAD;
              init_addr <= init_addr + ADDR_W'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: shift register advances on each falling sclk except after the last bit
  always_ff @(posedge serial_clk) begin
    if (state == S_LOAD) begin
      shreg <= init_word;
    end else if (host_fire) begin
      shreg <= host_req_data;
    end else if (half_end && sclk_q && (bit_cnt != BIT_LAST)) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_audio_codec_config_sequencer.sv
// Scoreboard bench: expected SPI words are queued as stimulus is driven and
// compared as each chip-select window closes; timing is checked per cycle.
module tb_audio_codec_config_sequencer;

  logic        serial_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic        host_req_valid = 1'b0;
  logic [15:0] host_req_data = '0;
  logic [15:0] init_word;
  logic [2:0]  init_addr;
  logic        host_req_ready, spi_chip_select, spi_sclk, spi_mosi;
  logic        init_done, stream_enable, busy;

  logic [15:0] tbl [8];
  logic [15:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          idle_viol = 0;
  int          base = 0;
  bit          mon_en = 1'b0;
  bit          drop_word = 1'b0;

  always #5 serial_clk = ~serial_clk;

  assign init_word = tbl[init_addr];

  audio_codec_config_sequencer dut (
    .serial_clk      (serial_clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .init_addr       (init_addr),
    .init_word       (init_word),
    .host_req_valid  (host_req_valid),
    .host_req_data   (host_req_data),
    .host_req_ready  (host_req_ready),
    .spi_chip_select (spi_chip_select),
    .spi_sclk        (spi_sclk),
    .spi_mosi        (spi_mosi),
    .init_done       (init_done),
    .stream_enable   (stream_enable),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(negedge serial_clk);
      cyc++;
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"}, spi_chip_select, 1);
    check({tag, "_sclk"}, spi_sclk, 0);
    check({tag, "_mosi"}, spi_mosi, 0);
    check({tag, "_addr"}, init_addr, 0);
    check({tag, "_done"}, init_done, 0);
    check({tag, "_stream"}, stream_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, host_req_ready, 0);
  endtask

  // SPI capture: mosi sampled while sclk is first seen high in each bit
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] cap = '0;
  int          edges = 0;
  int          low_cyc = 0;

  always @(negedge serial_clk) begin
    if (mon_en) begin
      if (spi_chip_select === 1'b0) begin
        low_cyc++;
        if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
          cap = {cap[14:0], spi_mosi};
          edges++;
        end
      end else if (spi_mosi !== 1'b0) begin
        idle_viol++;
      end
      if (spi_chip_select === 1'b1 && prev_cs === 1'b0) begin
        if (drop_word) begin
          drop_word = 1'b0;
        end else begin
          check("cs_low_cycles", low_cyc, 128);
          check("sclk_rises", edges, 16);
          if (exp_q.size() == 0) check("word_queued", exp_q.size(), 1);
          else check("spi_word", cap, exp_q.pop_front());
        end
        low_cyc = 0;
        edges = 0;
      end
      prev_cs = spi_chip_select;
      prev_sclk = spi_sclk;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{16'hA5C3, 16'h3C96, 16'h8001, 16'h7FFE, 16'hFFFF, 16'h0000, 16'h5AA5, 16'hC001};
    repeat (2) @(negedge serial_clk);
    check_reset_outputs("rst");
    mon_en = 1'b1;
    reset = 1'b0;
    @(negedge serial_clk);
    cyc = 0;

    // Full init sequence with cycle-exact timing
    cfg_start = 1'b1;
    push_init();
    check("idle_busy", busy, 0);
    go_to(1);
    cfg_start = 1'b0;
    check("load_busy", busy, 1);
    check("load_cs", spi_chip_select, 1);
    go_to(2);   check("shift_first_cs", spi_chip_select, 0);
    go_to(129); check("shift_last_cs", spi_chip_select, 0);
    go_to(130); check("gap_cs", spi_chip_select, 1);
    go_to(138); check("word1_addr", init_addr, 1);
    check("word1_load_cs", spi_chip_select, 1);
    go_to(300);
    cfg_start = 1'b1;
    host_req_valid = 1'b1;
    host_req_data = 16'hDEAD;
    #1 check("busy_ready", host_req_ready, 0);
    go_to(301);
    cfg_start = 1'b0;
    host_req_valid = 1'b0;
    go_to(960);  check("word7_addr", init_addr, 7);
    go_to(1096); check("done_early", init_done, 0);
    go_to(1097);
    check("done", init_done, 1);
    check("stream_on", stream_enable, 1);
    check("run_busy", busy, 0);
    check("run_ready", host_req_ready, 1);

    // Runtime host write goes straight to SHIFT
    go_to(1100);
    host_req_valid = 1'b1;
    host_req_data = 16'h1234;
    exp_q.push_back(16'h1234);
    #1 check("host_ready", host_req_ready, 1);
    go_to(1101);
    host_req_valid = 1'b0;
    check("host_no_load_cs", spi_chip_select, 0);
    check("host_stream", stream_enable, 1);
    go_to(1228); check("host_last_cs", spi_chip_select, 0);
    go_to(1229); check("host_gap_cs", spi_chip_select, 1);
    go_to(1236); check("host_gap_busy", busy, 1);
    go_to(1237);
    check("host_back_run", busy, 0);
    check("host_back_ready", host_req_ready, 1);
    check("host_stream_end", stream_enable, 1);

    // cfg_start beats a simultaneous host request; host word waits for init
    go_to(1240);
    cfg_start = 1'b1;
    host_req_valid = 1'b1;
    host_req_data = 16'h5A5A;
    push_init();
    exp_q.push_back(16'h5A5A);
    #1 check("coll_ready", host_req_ready, 0);
    go_to(1241);
    cfg_start = 1'b0;
    check("coll_done_clr", init_done, 0);
    check("coll_stream_clr", stream_enable, 0);
    check("coll_busy", busy, 1);
    while (host_req_ready !== 1'b1 && cyc < 1240 + 1200) go_to(cyc + 1);
    check("coll_host_cycle", cyc, 1240 + 1097);
    check("coll_done", init_done, 1);
    go_to(cyc + 1);
    host_req_valid = 1'b0;
    check("coll_host_shift", spi_chip_select, 0);
    base = cyc;
    while (busy !== 1'b0 && cyc < base + 200) go_to(cyc + 1);
    check("coll_host_finish", busy, 0);

    // Reset in the middle of a word abandons it
    go_to(cyc + 2);
    base = cyc;
    cfg_start = 1'b1;
    push_init();
    go_to(base + 1);
    cfg_start = 1'b0;
    go_to(base + 60);
    check("pre_rst_cs", spi_chip_select, 0);
    reset = 1'b1;
    drop_word = 1'b1;
    exp_q.delete();
    go_to(base + 61);
    check_reset_outputs("midrst");
    reset = 1'b0;
    go_to(base + 400);
    check("post_rst_idle", busy, 0);
    check("post_rst_cs", spi_chip_select, 1);
    check("post_rst_done", init_done, 0);

    go_to(cyc + 2);
    check("mosi_idle_low", idle_viol, 0);
    check("queue_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
